// File: rtl/qnna_tile_sched.sv
`timescale 1ns/1ps
// qnna_tile_sched: walks an M x N x K INT8 matmul over the QNNA MAC array in
// TILE x TILE output blocks, each covering K in KCHUNK-deep slices, issuing one
// tile command per slice and waiting for the array's completion.
module qnna_tile_sched #(
    parameter  int TILE   = 4,
    parameter  int KCHUNK = 8,
    parameter  int DIM_W  = 16,
    localparam int ML_W   = $clog2(TILE + 1),
    localparam int KL_W   = $clog2(KCHUNK + 1)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic             abort,
    input  logic [DIM_W-1:0] dim_m,
    input  logic [DIM_W-1:0] dim_n,
    input  logic [DIM_W-1:0] dim_k,
    input  logic             relu_en,
    input  logic             tile_done,
    output logic             tile_start,
    output logic [DIM_W-1:0] m_base,
    output logic [DIM_W-1:0] n_base,
    output logic [DIM_W-1:0] k_base,
    output logic [ML_W-1:0]  m_len,
    output logic [ML_W-1:0]  n_len,
    output logic [KL_W-1:0]  k_len,
    output logic             acc_clear,
    output logic             wr_back,
    output logic             relu_q,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // One extra bit so base + step never wraps for dims near 2^DIM_W-1.
    localparam int AW = DIM_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] dm_q, dn_q, dk_q;
    logic             err_q;

    logic             start_acc;
    logic             load;
    logic             zero_dim;
    logic [AW-1:0]    m_nx, n_nx, k_nx;

    logic [DIM_W-1:0] dm_s, dn_s, dk_s;
    logic [AW-1:0]    rem_m, rem_n, rem_k;
    logic [ML_W-1:0]  m_len_d, n_len_d;
    logic [KL_W-1:0]  k_len_d;
    logic             acc_clear_d, wr_back_d;

    assign zero_dim = (dim_m == '0) || (dim_n == '0) || (dim_k == '0);

    // State register, latched job parameters and registered command fields.
    // The base outputs double as the m0/n0/k0 loop counters.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= S_IDLE;
            dm_q      <= '0;
            dn_q      <= '0;
            dk_q      <= '0;
            err_q     <= 1'b0;
            relu_q    <= 1'b0;
            m_base    <= '0;
            n_base    <= '0;
            k_base    <= '0;
            m_len     <= '0;
            n_len     <= '0;
            k_len     <= '0;
            acc_clear <= 1'b0;
            wr_back   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                dm_q   <= dim_m;
                dn_q   <= dim_n;
                dk_q   <= dim_k;
                relu_q <= relu_en;
                err_q  <= zero_dim;
            end
            if (load) begin
                m_base    <= m_nx[DIM_W-1:0];
                n_base    <= n_nx[DIM_W-1:0];
                k_base    <= k_nx[DIM_W-1:0];
                m_len     <= m_len_d;
                n_len     <= n_len_d;
                k_len     <= k_len_d;
                acc_clear <= acc_clear_d;
                wr_back   <= wr_back_d;
            end
        end
    end

    // Next-state logic and loop advance (K innermost, then N, then M).
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        load      = 1'b0;
        m_nx      = {1'b0, m_base};
        n_nx      = {1'b0, n_base};
        k_nx      = {1'b0, k_base};
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    load      = 1'b1;
                    m_nx      = '0;
                    n_nx      = '0;
                    k_nx      = '0;
                    state_d   = zero_dim ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (tile_done) state_d = S_NEXT;
            end
            S_NEXT: begin
                state_d = S_ISSUE;
                k_nx    = {1'b0, k_base} + AW'(KCHUNK);
                if (k_nx >= {1'b0, dk_q}) begin
                    k_nx = '0;
                    n_nx = {1'b0, n_base} + AW'(TILE);
                    if (n_nx >= {1'b0, dn_q}) begin
                        n_nx = '0;
                        m_nx = {1'b0, m_base} + AW'(TILE);
                        if (m_nx >= {1'b0, dm_q}) state_d = S_FIN;
                    end
                end
                load = (state_d == S_ISSUE);
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort wins over everything, including a coincident tile_done.
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
            load    = 1'b0;
        end
    end

    // Command field values for the slice about to be issued; dims come from
    // the inputs on the accepting cycle, from the latched copy afterwards.
    always_comb begin
        dm_s        = (state_q == S_IDLE) ? dim_m : dm_q;
        dn_s        = (state_q == S_IDLE) ? dim_n : dn_q;
        dk_s        = (state_q == S_IDLE) ? dim_k : dk_q;
        rem_m       = {1'b0, dm_s} - m_nx;
        rem_n       = {1'b0, dn_s} - n_nx;
        rem_k       = {1'b0, dk_s} - k_nx;
        m_len_d     = (rem_m >= AW'(TILE))   ? ML_W'(TILE)   : ML_W'(rem_m);
        n_len_d     = (rem_n >= AW'(TILE))   ? ML_W'(TILE)   : ML_W'(rem_n);
        k_len_d     = (rem_k >= AW'(KCHUNK)) ? KL_W'(KCHUNK) : KL_W'(rem_k);
        acc_clear_d = (k_nx == '0);
        wr_back_d   = ((k_nx + AW'(KCHUNK)) >= {1'b0, dk_s});
    end

    // Status strobes decoded from the state register.
    always_comb begin
        tile_start = (state_q == S_ISSUE);
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_FIN);
        err        = (state_q == S_FIN) && err_q;
    end

endmodule

// File: doc/qnna_tile_sched.md
# qnna_tile_sched

Tile scheduler that sequences an M×N×K INT8 matrix multiply onto the fixed-size QNNA MAC array. It sits between the CSR block and the MAC array. On a kick it latches the CSR dimensions and walks the output in TILE×TILE blocks, each covering K in KCHUNK-deep slices. For every slice it issues one tile command, then waits for the array's per-tile completion. It reports busy, done and error back to the CSR block for status and IRQ.

## Interface
- TILE, 4: MAC array edge; output block is up to TILE×TILE.
- KCHUNK, 8: max K depth per tile command.
- DIM_W, 16: width of dimension and offset fields.

- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle kick from CSR
- abort  in  1  synchronous cancel
- dim_m, dim_n, dim_k  in  DIM_W each  matrix dimensions, sampled on accepted start
- relu_en  in  1  ReLU enable, sampled on accepted start
- tile_done  in  1  MAC array finished the current tile command
- tile_start  out  1  one-cycle tile command strobe
- m_base, n_base, k_base  out  DIM_W each  origin of current tile/slice
- m_len, n_len  out  $clog2(TILE+1) each  valid rows/cols (1..TILE)
- k_len  out  $clog2(KCHUNK+1)  valid K depth (1..KCHUNK)
- acc_clear  out  1  first K slice of this output tile: clear accumulators
- wr_back  out  1  last K slice: write results back (apply ReLU if relu_q)
- relu_q  out  1  latched relu_en
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse
- err  out  1  one-cycle pulse, zero dimension on start

## Operation
- States: IDLE, ISSUE, WAIT, NEXT, FIN.
- IDLE: start=1 latches dims and relu_en and clears m0/n0/k0.
  - All dims non-zero: go to ISSUE.
  - Any dim zero: go to FIN with an error flag set.
- Start is ignored in every other state.
- ISSUE: tile_start=1 for exactly this cycle, then go to WAIT.
- WAIT: hold until tile_done=1, then go to NEXT. tile_done is ignored in every other state.
- NEXT: advance the loop, K innermost, then N, then M:
  - k0 += KCHUNK.
  - If k0 ≥ dim_k: k0=0, n0 += TILE.
  - If n0 ≥ dim_n: n0=0, m0 += TILE.
  - If m0 ≥ dim_m: go to FIN, else go to ISSUE.
- FIN: done=1 for one cycle, plus err=1 if the error flag is set. Then go to IDLE.
- Length fields:
  - m_len = min(TILE, dim_m−m0)
  - n_len = min(TILE, dim_n−n0)
  - k_len = min(KCHUNK, dim_k−k0)
- acc_clear = (k0==0). wr_back = (k0+KCHUNK ≥ dim_k).
- Offset arithmetic is DIM_W+1 bits wide so that dim = 2^DIM_W−1 cannot wrap.
- Command outputs (bases, lens, acc_clear, wr_back) are registered. They are stable from the ISSUE cycle through the end of WAIT.
- busy=1 in ISSUE, WAIT, NEXT and FIN.
- abort=1 in any non-IDLE state: go to IDLE next cycle, no done and no err. Abort has priority over tile_done. An in-flight array command is the array's concern.
- Total tile commands per job = ceil(M/TILE)·ceil(N/TILE)·ceil(K/KCHUNK).

## Timing
- Reset values: state IDLE, all outputs 0, m0/n0/k0 0, relu_q 0.
- start sampled at cycle t: tile_start at t+1, WAIT from t+2.
- tile_done sampled at cycle c: NEXT at c+1, then either the next tile_start or done at c+2.
- Per-tile overhead is 3 cycles plus array latency (tile_done may come as early as the first WAIT cycle).
- Zero-dimension start at t: done=err=1 at t+1, busy=1 only at t+1.
- Reset asserted mid-job: all outputs 0 immediately. The next start after release begins a fresh job.

## Test plan
- TILE=4, KCHUNK=8, dims 4/4/8:
  - Exactly one tile_start with bases 0, lens 4/4/8, acc_clear=1, wr_back=1.
  - With tile_done 3 cycles after the strobe, done follows 2 cycles later.
- Dims 5/4/9:
  - 4 commands in order (m,k) = (0,0),(0,8),(4,0),(4,8).
  - m_len 4,4,1,1. k_len 8,1,8,1.
  - acc_clear 1,0,1,0. wr_back 0,1,0,1.
  - Then one done pulse.
- dim_n=0 -> done=err=1 one cycle after start, no tile_start. A second start while busy during a 5/4/9 job changes nothing.
- Abort asserted in WAIT of the 2nd command together with tile_done -> IDLE next cycle, busy=0, no done, no further tile_start.
- wb_rst_i pulsed asynchronously mid-WAIT -> all outputs 0 immediately. A subsequent 4/4/8 job completes normally.
- dim_m=65535, dim_n=1, dim_k=1 -> 16384 commands, last m_base=65532, last m_len=3, no wrap.
